// File: rtl/axi_stream_extract_header.sv
// Strips a 1..DATA_BYTE_WD-byte header from the front of each AXI-Stream packet, presents it
// on a side port and realigns the remaining payload to byte 0 (MSB-first byte order).
module axi_stream_extract_header #(
   parameter int unsigned DATA_WD      = 32,
   parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
   parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_strip,
   input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
   output logic                    ready_strip,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   output logic                    valid_header,
   output logic [DATA_WD-1:0]      data_header,
   output logic [DATA_BYTE_WD-1:0] keep_header,
   input  logic                    ready_header,
   output logic                    err_short
);

   localparam int unsigned HW = BYTE_CNT_WD + 1;
   localparam logic [HW-1:0] BytesW = HW'(DATA_BYTE_WD);

   typedef enum logic [1:0] {StIdle, StHead, StBody, StFlush} state_e;

   state_e                  state_q, state_d;
   logic [HW-1:0]           h_q, h_d;
   logic [DATA_WD-1:0]      res_data_q, res_data_d;
   logic [DATA_BYTE_WD-1:0] res_keep_q, res_keep_d;
   logic [DATA_WD-1:0]      dout_q, dout_d;
   logic [DATA_BYTE_WD-1:0] kout_q, kout_d;
   logic                    lout_q, lout_d;
   logic                    vout_q, vout_d;
   logic [DATA_WD-1:0]      hdata_q, hdata_d;
   logic [DATA_BYTE_WD-1:0] hkeep_q, hkeep_d;
   logic                    vhdr_q, vhdr_d;
   logic                    err_q, err_d;

   logic [BYTE_CNT_WD-1:0]  lo_bytes;
   logic [DATA_WD-1:0]      in_hi_data, in_lo_data;
   logic [DATA_BYTE_WD-1:0] in_hi_keep, in_lo_keep;
   logic                    in_short, in_acc, out_free;

   // First H bytes of the beat right-aligned, and the rest moved up to the MSB end.
   // H == DATA_BYTE_WD shifts the low part out completely.
   assign lo_bytes   = BYTE_CNT_WD'(BytesW - h_q);
   assign in_hi_data = data_in >> {lo_bytes, 3'b000};
   assign in_hi_keep = keep_in >> lo_bytes;
   assign in_lo_data = data_in << {h_q, 3'b000};
   assign in_lo_keep = keep_in << h_q;
   // keep is contiguous from the MSB, so the H-th byte's enable tells whether H bytes exist.
   assign in_short   = last_in & ~keep_in[lo_bytes];
   assign out_free   = ~vout_q | ready_out;
   assign in_acc     = valid_in & ready_in;

   always_comb begin
      state_d    = state_q;
      h_d        = h_q;
      res_data_d = res_data_q;
      res_keep_d = res_keep_q;
      dout_d     = dout_q;
      kout_d     = kout_q;
      lout_d     = lout_q;
      vout_d     = vout_q & ~ready_out;
      hdata_d    = hdata_q;
      hkeep_d    = hkeep_q;
      vhdr_d     = vhdr_q & ~ready_header;
      err_d      = 1'b0;
      ready_strip = 1'b0;
      ready_in    = 1'b0;

      unique case (state_q)
         StIdle: begin
            ready_strip = 1'b1;
            if (valid_strip) begin
               h_d     = HW'(byte_strip_cnt) + HW'(1);
               state_d = StHead;
            end
         end
         StHead: begin
            ready_in = ~vhdr_q;
            if (in_acc) begin
               hdata_d    = in_hi_data;
               hkeep_d    = in_hi_keep;
               vhdr_d     = 1'b1;
               res_data_d = in_lo_data;
               res_keep_d = in_lo_keep;
               err_d      = in_short;
               if (!last_in)             state_d = StBody;
               else if (in_lo_keep != '0) state_d = StFlush;
               else                       state_d = StIdle;
            end
         end
         StBody: begin
            ready_in = out_free;
            if (in_acc) begin
               dout_d     = res_data_q | in_hi_data;
               kout_d     = res_keep_q | in_hi_keep;
               vout_d     = 1'b1;
               lout_d     = last_in & (in_lo_keep == '0);
               res_data_d = in_lo_data;
               res_keep_d = in_lo_keep;
               if (last_in) state_d = (in_lo_keep == '0) ? StIdle : StFlush;
            end
         end
         StFlush: begin
            if (out_free) begin
               dout_d  = res_data_q;
               kout_d  = res_keep_q;
               lout_d  = 1'b1;
               vout_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         h_q        <= '0;
         res_data_q <= '0;
         res_keep_q <= '0;
         dout_q     <= '0;
         kout_q     <= '0;
         lout_q     <= 1'b0;
         vout_q     <= 1'b0;
         hdata_q    <= '0;
         hkeep_q    <= '0;
         vhdr_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         h_q        <= h_d;
         res_data_q <= res_data_d;
         res_keep_q <= res_keep_d;
         dout_q     <= dout_d;
         kout_q     <= kout_d;
         lout_q     <= lout_d;
         vout_q     <= vout_d;
         hdata_q    <= hdata_d;
         hkeep_q    <= hkeep_d;
         vhdr_q     <= vhdr_d;
         err_q      <= err_d;
      end
   end

   assign valid_out    = vout_q;
   assign data_out     = dout_q;
   assign keep_out     = kout_q;
   assign last_out     = lout_q;
   assign valid_header = vhdr_q;
   assign data_header  = hdata_q;
   assign keep_header  = hkeep_q;
   assign err_short    = err_q;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Randomized bench for axi_stream_extract_header: a byte-list packet model predicts header,
// payload beats and err_short; one negedge monitor compares every transfer and stall.
module tb_axi_stream_extract_header;

   localparam int DW = 32;
   localparam int BW = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid_strip = 1'b0;
   logic [CW-1:0] byte_strip_cnt = '0;
   logic          ready_strip;
   logic          valid_in = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [BW-1:0] keep_in = '0;
   logic          last_in = 1'b0;
   logic          ready_in;
   logic          valid_out;
   logic [DW-1:0] data_out;
   logic [BW-1:0] keep_out;
   logic          last_out;
   logic          ready_out = 1'b0;
   logic          valid_header;
   logic [DW-1:0] data_header;
   logic [BW-1:0] keep_header;
   logic          ready_header = 1'b0;
   logic          err_short;

   always #5 clk = ~clk;

   axi_stream_extract_header #(
      .DATA_WD(DW), .DATA_BYTE_WD(BW), .BYTE_CNT_WD(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
      .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
      .ready_in(ready_in),
      .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
      .ready_out(ready_out),
      .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header),
      .ready_header(ready_header), .err_short(err_short)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic summary();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
   endtask

   task automatic abort(input string what);
      n_err++;
      $display("FAIL %s: timed out at %0t", what, $time);
      summary();
      $finish;
   endtask

   // Packet bytes, the beats carrying them, and the model's prediction.
   logic [7:0]  pkt[$];
   logic [31:0] bd[$];
   logic [3:0]  bk[$];
   logic [31:0] m_hd;
   logic [3:0]  m_hk;
   logic        m_short;
   logic [31:0] m_pd[$];
   logic [3:0]  m_pk[$];
   logic        m_pl[$];

   logic [31:0] q_hd[$];
   logic [3:0]  q_hk[$];
   logic [31:0] q_pd[$];
   logic [3:0]  q_pk[$];
   logic        q_pl[$];

   logic drv_head = 1'b0;
   logic drv_short = 1'b0;

   task automatic prepare(input int h);
      int L;
      logic [31:0] d;
      logic [3:0]  k;
      L = pkt.size();
      bd.delete();
      bk.delete();
      for (int s = 0; s < L; s += BW) begin
         d = '0;
         k = '0;
         for (int j = 0; j < BW; j++) begin
            if (s + j < L) begin
               d[31-8*j -: 8] = pkt[s+j];
               k[3-j] = 1'b1;
            end else begin
               d[31-8*j -: 8] = 8'($urandom);
            end
         end
         bd.push_back(d);
         bk.push_back(k);
      end
      // Header = first h stream bytes of beat 0, last one landing in the low byte.
      m_hd = '0;
      m_hk = '0;
      for (int i = 0; i < h; i++) begin
         m_hd = (m_hd << 8) | 32'(bd[0][31-8*i -: 8]);
         m_hk = (m_hk << 1) | 4'(bk[0][3-i]);
      end
      m_short = (L < h);
      m_pd.delete();
      m_pk.delete();
      m_pl.delete();
      for (int s = h; s < L; s += BW) begin
         d = '0;
         k = '0;
         for (int j = 0; j < BW; j++) begin
            if (s + j < L) begin
               d[31-8*j -: 8] = pkt[s+j];
               k[3-j] = 1'b1;
            end
         end
         m_pd.push_back(d);
         m_pk.push_back(k);
         m_pl.push_back(s + BW >= L);
      end
   endtask

   task automatic send(input int h);
      int  t;
      logic hs;
      q_hd.push_back(m_hd);
      q_hk.push_back(m_hk);
      foreach (m_pd[i]) begin
         q_pd.push_back(m_pd[i]);
         q_pk.push_back(m_pk[i]);
         q_pl.push_back(m_pl[i]);
      end
      valid_strip    = 1'b1;
      byte_strip_cnt = CW'(h - 1);
      t = 0;
      do begin
         @(negedge clk);
         hs = ready_strip;
         @(posedge clk);
         #1;
         if (!hs && ++t > 1000) abort("strip_handshake");
      end while (!hs);
      valid_strip    = 1'b0;
      byte_strip_cnt = CW'($urandom);
      for (int b = 0; b < bd.size(); b++) begin
         repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
            @(posedge clk);
            #1;
         end
         valid_in  = 1'b1;
         data_in   = bd[b];
         keep_in   = bk[b];
         last_in   = (b == bd.size() - 1);
         drv_head  = (b == 0);
         drv_short = m_short;
         t = 0;
         do begin
            @(negedge clk);
            hs = ready_in;
            @(posedge clk);
            #1;
            if (!hs && ++t > 1000) abort("beat_handshake");
         end while (!hs);
         valid_in = 1'b0;
         drv_head = 1'b0;
         data_in  = $urandom;
         keep_in  = 4'($urandom);
         last_in  = 1'($urandom);
      end
      if (m_pd.size() == 0) begin
         @(negedge clk);
         check("ready_strip_after_header_only", 32'(ready_strip), 32'd1);
         @(posedge clk);
         #1;
      end
   endtask

   // Output monitor: transfers against the model queues, stall stability, err_short timing.
   logic        mon_en = 1'b0;
   logic        exp_err = 1'b0;
   logic        p_vo = 1'b0, p_ro = 1'b0, p_lo = 1'b0, p_vh = 1'b0, p_rh = 1'b0;
   logic [31:0] p_do = '0, p_dh = '0;
   logic [3:0]  p_ko = '0, p_kh = '0;

   always @(negedge clk) begin
      logic [31:0] mask;
      if (rst_n && mon_en) begin
         check("err_short", 32'(err_short), 32'(exp_err));
         exp_err = valid_in && ready_in && drv_head && drv_short;
         if (p_vo && !p_ro) begin
            check("stall_valid_out", 32'(valid_out), 32'd1);
            check("stall_data_out", data_out, p_do);
            check("stall_keep_out", 32'(keep_out), 32'(p_ko));
            check("stall_last_out", 32'(last_out), 32'(p_lo));
         end
         if (p_vh && !p_rh) begin
            check("stall_valid_header", 32'(valid_header), 32'd1);
            check("stall_data_header", data_header, p_dh);
            check("stall_keep_header", 32'(keep_header), 32'(p_kh));
         end
         if (valid_out && ready_out) begin
            if (q_pd.size() == 0) begin
               check("unexpected_payload_beat", 32'(valid_out), 32'd0);
            end else begin
               for (int j = 0; j < BW; j++) mask[31-8*j -: 8] = {8{q_pk[0][3-j]}};
               check("payload_data", data_out & mask, q_pd[0]);
               check("payload_keep", 32'(keep_out), 32'(q_pk[0]));
               check("payload_last", 32'(last_out), 32'(q_pl[0]));
               void'(q_pd.pop_front());
               void'(q_pk.pop_front());
               void'(q_pl.pop_front());
            end
         end
         if (valid_header && ready_header) begin
            if (q_hd.size() == 0) begin
               check("unexpected_header", 32'(valid_header), 32'd0);
            end else begin
               check("header_data", data_header, q_hd[0]);
               check("header_keep", 32'(keep_header), 32'(q_hk[0]));
               void'(q_hd.pop_front());
               void'(q_hk.pop_front());
            end
         end
         p_vo = valid_out; p_ro = ready_out; p_do = data_out; p_ko = keep_out; p_lo = last_out;
         p_vh = valid_header; p_rh = ready_header; p_dh = data_header; p_kh = keep_header;
      end
   end

   logic rdy_en = 1'b0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_en) begin
            ready_out    = ($urandom_range(0, 3) != 0);
            ready_header = ($urandom_range(0, 3) != 0);
         end
      end
   end

   initial begin
      int t;
      #23 rst_n = 1'b1;
      @(negedge clk);
      check("reset_ready_strip", 32'(ready_strip), 32'd1);
      check("reset_ready_in", 32'(ready_in), 32'd0);
      check("reset_valid_out", 32'(valid_out), 32'd0);
      check("reset_valid_header", 32'(valid_header), 32'd0);
      check("reset_err_short", 32'(err_short), 32'd0);
      check("reset_keep_out", 32'(keep_out), 32'd0);
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      rdy_en = 1'b1;

      // H=2 across three beats, last one overflows into a flush beat.
      pkt = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h11,
             8'h22, 8'h33, 8'h44, 8'h55};
      prepare(2);
      check("pin1_header", m_hd, 32'h0000AABB);
      check("pin1_keep_header", 32'(m_hk), 32'h3);
      check("pin1_beat0", m_pd[0], 32'hCCDDEEFF);
      check("pin1_beat1", m_pd[1], 32'h00112233);
      check("pin1_beat2", m_pd[2], 32'h44550000);
      check("pin1_keep2", 32'(m_pk[2]), 32'hC);
      check("pin1_last2", 32'(m_pl[2]), 32'd1);
      send(2);

      // H=4: header is beat 0, payload beats pass through unchanged.
      pkt.delete();
      for (int i = 0; i < 12; i++) pkt.push_back(8'(i));
      prepare(4);
      check("pin2_header", m_hd, 32'h00010203);
      check("pin2_nbeats", 32'(m_pd.size()), 32'd2);
      check("pin2_beat1", m_pd[1], 32'h08090A0B);
      send(4);

      // H=1 single full beat.
      pkt = {8'h11, 8'h22, 8'h33, 8'h44};
      prepare(1);
      check("pin3_header", m_hd, 32'h00000011);
      check("pin3_keep_header", 32'(m_hk), 32'h1);
      check("pin3_beat0", m_pd[0], 32'h22334400);
      check("pin3_keep0", 32'(m_pk[0]), 32'hE);
      send(1);

      // H=4 single beat: header only.
      pkt = {8'h5A, 8'h6B, 8'h7C, 8'h8D};
      prepare(4);
      check("pin4_header", m_hd, 32'h5A6B7C8D);
      check("pin4_nbeats", 32'(m_pd.size()), 32'd0);
      send(4);

      // H=3 with only two valid bytes: short packet.
      pkt = {8'hAA, 8'hBB};
      prepare(3);
      check("pin5_short", 32'(m_short), 32'd1);
      check("pin5_header_hi", 32'(m_hd[31:8]), 32'h0000AABB);
      check("pin5_keep_header", 32'(m_hk), 32'h6);
      send(3);

      for (int p = 0; p < 200; p++) begin
         int L;
         int h;
         h = $urandom_range(1, 4);
         L = $urandom_range(1, 14);
         pkt.delete();
         for (int i = 0; i < L; i++) pkt.push_back(8'($urandom));
         prepare(h);
         send(h);
      end

      t = 0;
      while (q_pd.size() != 0 || q_hd.size() != 0) begin
         @(posedge clk);
         if (++t > 2000) abort("drain");
      end
      repeat (3) @(posedge clk);
      summary();
      $finish;
   end

endmodule
